// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the 64-tap FIR engine.
package fir_pkg;

    localparam int unsigned TAPS = 64;   // number of taps
    localparam int unsigned DW   = 16;   // sample width
    localparam int unsigned CW   = 16;   // coefficient width
    localparam int unsigned AW   = 6;    // tap / history index width
    localparam int unsigned OW   = 41;   // accumulator / result width
    localparam int unsigned PW   = DW + CW; // full product width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : fir_pkg

// File: rtl/fir_if.sv
// Sample / coefficient / result bus of the FIR engine.
//   master : sample source + coefficient loader + result consumer
//   slave  : fir_core
//   start, valid_in, din : sample offer
//   cload, caddr, cin    : coefficient write port
//   dout, valid_out      : filter result and its one-cycle strobe
interface fir_if;
    import fir_pkg::*;

    logic                 start;
    logic                 valid_in;
    logic signed [DW-1:0] din;
    logic                 cload;
    logic [AW-1:0]        caddr;
    logic signed [CW-1:0] cin;
    logic signed [OW-1:0] dout;
    logic                 valid_out;

    modport master (
        output start, valid_in, din, cload, caddr, cin,
        input  dout, valid_out
    );

    modport slave (
        input  start, valid_in, din, cload, caddr, cin,
        output dout, valid_out
    );

endinterface : fir_if

// File: rtl/fir_mac.sv
// Registered signed multiplier feeding a 41-bit accumulator.
//   clk, rst  : clock, async active-high reset
//   clr       : zero product and accumulator
//   en        : register a new product and add the previous one
//   coef      : signed coefficient operand
//   sample    : signed sample operand
//   acc_sum_c : accumulator plus the pending product (combinational)
module fir_mac
    import fir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] sample,
    output logic signed [OW-1:0] acc_sum_c
);

    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [OW-1:0] acc_q, acc_d;

    // The product register is one stage ahead of the accumulator.
    assign acc_sum_c = acc_q + OW'(prod_q);

    // Next product / accumulator.
    always_comb begin
        prod_d = prod_q;
        acc_d  = acc_q;
        if (clr) begin
            prod_d = '0;
            acc_d  = '0;
        end else if (en) begin
            prod_d = PW'(coef) * PW'(sample);
            acc_d  = acc_sum_c;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

endmodule : fir_mac

// File: rtl/fir_core.sv
// 64-tap direct-form FIR engine: coefficient RAM, circular sample history,
// control FSM and one time-multiplexed MAC.
//   clk, rst : clock, async active-high reset
//   bus      : fir_if.slave (sample in, coefficient write, result out)
// Optional feature macro FIR_CLEAR_ON_LOAD_EN: a coefficient write also
// clears the sample history and rewinds the write pointer.
module fir_core
    import fir_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fir_if.slave bus
);

    state_e               state_q, state_d;
    logic signed [CW-1:0] coef_q [TAPS];
    logic signed [CW-1:0] coef_d [TAPS];
    logic signed [DW-1:0] hist_q [TAPS];
    logic signed [DW-1:0] hist_d [TAPS];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        tap_q, tap_d;
    logic signed [OW-1:0] dout_q, dout_d;
    logic                 valid_out_q, valid_out_d;

    logic                 accept;
    logic                 mac_clr;
    logic                 mac_en;
    logic [AW-1:0]        rd_idx;
    logic signed [OW-1:0] acc_sum;

    assign accept = bus.start && bus.valid_in && !bus.cload && (state_q == IDLE);

    // wptr already points past the newest sample, so x[n-k] sits at wptr-1-k.
    assign rd_idx = wptr_q - AW'(1) - tap_q;

    assign bus.dout      = dout_q;
    assign bus.valid_out = valid_out_q;

    fir_mac u_mac (
        .clk       (clk),
        .rst       (rst),
        .clr       (mac_clr),
        .en        (mac_en),
        .coef      (coef_q[tap_q]),
        .sample    (hist_q[rd_idx]),
        .acc_sum_c (acc_sum)
    );

    // Coefficient writes and sample history update.
    always_comb begin
        coef_d = coef_q;
        hist_d = hist_q;
        wptr_d = wptr_q;
        if (bus.cload) begin
            coef_d[bus.caddr] = bus.cin;
        end
        if (accept) begin
            hist_d[wptr_q] = bus.din;
            wptr_d         = wptr_q + AW'(1);
        end
`ifdef FIR_CLEAR_ON_LOAD_EN
        if (bus.cload) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_d[i] = '0;
            end
            wptr_d = '0;
        end
`else
`endif
    end

    // Control FSM: one tap per MAC cycle; DONE folds in the last product.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        dout_d      = dout_q;
        valid_out_d = 1'b0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    tap_d   = '0;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                tap_d  = tap_q + AW'(1);
                if (tap_q == AW'(TAPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                mac_en      = 1'b1;
                dout_d      = acc_sum;
                valid_out_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, storage and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            wptr_q      <= '0;
            dout_q      <= '0;
            valid_out_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            wptr_q      <= wptr_d;
            dout_q      <= dout_d;
            valid_out_q <= valid_out_d;
            coef_q      <= coef_d;
            hist_q      <= hist_d;
        end
    end

endmodule : fir_core

// File: tb/tb_fir_core.sv
// Directed, table-driven bench for fir_core (default build).
module tb_fir_core;

    typedef struct {
        logic signed [15:0] x;
        logic signed [40:0] y;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fir_if bus ();

    fir_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b1;
        bus.valid_in = 1'b0;
        bus.din      = '0;
        bus.cload    = 1'b0;
        bus.caddr    = '0;
        bus.cin      = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_coef(input int a, input logic signed [15:0] v);
        @(negedge clk);
        bus.cload = 1'b1;
        bus.caddr = 6'(a);
        bus.cin   = v;
        @(negedge clk);
        bus.cload = 1'b0;
    endtask

    // Offer one sample, optionally keep offering 7 for 'hold' cycles while busy,
    // then wait (bounded) for the result strobe.
    task automatic do_sample(input logic signed [15:0] x, input int hold,
                             output logic signed [40:0] res, output int lat);
        res = '0;
        lat = -1;
        @(negedge clk);
        bus.din      = x;
        bus.start    = 1'b1;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.din      = 16'sd7;
        bus.valid_in = (hold > 0);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c >= hold) bus.valid_in = 1'b0;
            if (bus.valid_out) begin
                lat = c;
                res = bus.dout;
                break;
            end
        end
        bus.valid_in = 1'b0;
    endtask

    // Offer a sample under a drop condition and count result strobes.
    task automatic offer(input logic st, input logic cl, input int n, output int pulses);
        pulses = 0;
        @(negedge clk);
        bus.din      = 16'sd7;
        bus.valid_in = 1'b1;
        bus.start    = st;
        bus.cload    = cl;
        bus.caddr    = 6'd5;
        bus.cin      = 16'sd6;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
        bus.valid_in = 1'b0;
        bus.cload    = 1'b0;
        bus.start    = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
    endtask

    vec_t imp_tab [65];
    vec_t fs_tab  [64];
    vec_t sgn_tab [2];

    initial begin
        logic signed [40:0] res;
        int                 lat;
        int                 pulses;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();

        // Expected-value tables.
        for (int i = 0; i < 65; i++) begin
            imp_tab[i].x = (i == 0) ? 16'sd1 : 16'sd0;
            imp_tab[i].y = (i < 64) ? 41'(i + 1) : 41'sd0;
        end
        for (int i = 0; i < 64; i++) begin
            fs_tab[i].x = -16'sd32768;
            fs_tab[i].y = 41'(64'(i + 1) << 30);
        end
        sgn_tab[0].x = 16'sd5;  sgn_tab[0].y = -41'sd10;
        sgn_tab[1].x = -16'sd7; sgn_tab[1].y = 41'sd29;

        // Reset with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start    = 1'($urandom);
            bus.valid_in = 1'($urandom);
            bus.din      = 16'($urandom);
            bus.cload    = 1'($urandom);
            bus.caddr    = 6'($urandom);
            bus.cin      = 16'($urandom);
        end
        #1;
        check("rst_dout", bus.dout, 0);
        check("rst_valid", 64'(bus.valid_out), 0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        do_sample(16'sd100, 0, res, lat);
        check("zero_coef_res", res, 0);
        check("zero_coef_lat", lat, 65);

        // Impulse response at the maximum sample rate.
        apply_reset();
        for (int k = 0; k < 64; k++) load_coef(k, 16'(k + 1));
        for (int i = 0; i < 65; i++) begin
            do_sample(imp_tab[i].x, 0, res, lat);
            check($sformatf("imp_res_%0d", i), res, imp_tab[i].y);
            check($sformatf("imp_lat_%0d", i), lat, 65);
        end
        @(posedge clk);
        #1;
        check("pulse_width", 64'(bus.valid_out), 0);

        // Full-scale magnitude.
        apply_reset();
        for (int k = 0; k < 64; k++) load_coef(k, -16'sd32768);
        for (int i = 0; i < 64; i++) begin
            do_sample(fs_tab[i].x, 0, res, lat);
            check($sformatf("fs_res_%0d", i), res, fs_tab[i].y);
        end
        check("fs_final", bus.dout, 64'sd68719476736);
        check("fs_sign_bit", 64'(bus.dout[40]), 0);

        // Signed arithmetic, including sign extension of a negative result.
        apply_reset();
        load_coef(0, -16'sd2);
        load_coef(1, 16'sd3);
        for (int i = 0; i < 2; i++) begin
            do_sample(sgn_tab[i].x, 0, res, lat);
            check($sformatf("sgn_res_%0d", i), res, sgn_tab[i].y);
        end

        // Drop rules, observed through the impulse pattern.
        apply_reset();
        for (int k = 0; k < 64; k++) load_coef(k, 16'(k + 1));
        do_sample(16'sd1, 40, res, lat);
        check("drop_busy_res", res, 1);
        check("drop_busy_lat", lat, 65);
        @(posedge clk);
        #1;
        check("drop_busy_no_extra", 64'(bus.valid_out), 0);
        offer(1'b1, 1'b1, 5, pulses);
        check("drop_cload_pulses", pulses, 0);
        offer(1'b0, 1'b0, 5, pulses);
        check("drop_nostart_pulses", pulses, 0);
        do_sample(16'sd0, 0, res, lat);
        check("drop_history_res", res, 2);

        // Reset mid-computation aborts it.
        check("pre_abort_dout", bus.dout, 2);
        @(negedge clk);
        bus.din      = 16'sd3;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_dout_in_rst", bus.dout, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_dout", bus.dout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fir_core
